// File: rtl/stageex_md.sv
// ---------------------------------------------------------------------------
// stageex_md : execute stage with integer ALU and multiply/divide unit
//
// Purpose
//   Single-issue execute stage. ALU ops complete in one cycle (result and
//   rs1/rs2 branch compare registered at the accepting edge). Multiply and
//   divide ops run iteratively, one radix-2 step per cycle, for XLEN cycles
//   in CALC, then present the sign-corrected result in DONE.
//
// Configuration
//   STAGEEX_MD_FASTMUL_EN : when defined, MUL/MULH/MULHSU/MULHU use a
//   single-cycle combinational multiplier and follow ALU timing; DIV/REM
//   stay iterative. When undefined, all MD ops are iterative and no
//   combinational multiplier exists.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_valid / o_ready       upstream handshake (o_ready only in IDLE)
//   i_flush                 kill in-flight op / discard this cycle's request
//   i_opa_sel, i_opb_sel    operand select (0: rs1/rs2, 1: pc/imm)
//   i_br_un                 unsigned branch compare
//   i_pc, i_rs1_data,
//   i_rs2_data, i_imm       XLEN-wide operands
//   i_alu_op                ALU operation
//   i_md_en, i_md_op        multiply/divide enable and operation
//   o_valid                 one-cycle result pulse
//   o_result                registered result (holds when o_valid low)
//   o_br_less, o_br_equal   registered rs1-vs-rs2 compare
//   o_busy                  iterative op in progress
// ---------------------------------------------------------------------------
module stageex_md #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  input  logic            i_opa_sel,
  input  logic            i_opb_sel,
  input  logic            i_br_un,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [3:0]      i_alu_op,
  input  logic            i_md_en,
  input  logic [2:0]      i_md_op,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_br_less,
  output logic            o_br_equal,
  output logic            o_busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     cnt_q;
  logic              valid_q;
  logic              busy_q;
  logic [XLEN-1:0]   result_q;
  logic              brLess_q;
  logic              brEqual_q;
  logic              pendLess_q;
  logic              pendEqual_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   dividend_q;
  logic [2:0]        op_q;
  logic              negQ_q;
  logic              negR_q;
  logic              divZero_q;

  logic              accept;
  logic              iterStart;
  logic [XLEN-1:0]   opA;
  logic [XLEN-1:0]   opB;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   aluRes;
  logic [XLEN-1:0]   issueRes_d;
  logic              brLess_d;
  logic              brEqual_d;
  logic              signA;
  logic              signB;
  logic              negA;
  logic              negB;
  logic [XLEN-1:0]   magA;
  logic [XLEN-1:0]   magB;

  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result_d;

  // Ready is suppressed while reset is held so nothing is accepted on the
  // reset edge; a flush in the same cycle discards the request outright.
  assign o_ready = (state_q == IDLE) && !i_reset;
  assign accept  = i_valid && o_ready && !i_flush;

  // Single-cycle ALU on the selected operands, plus the rs1/rs2 branch
  // compare that is always made on the register operands.
  always_comb begin
    opA    = i_opa_sel ? i_pc  : i_rs1_data;
    opB    = i_opb_sel ? i_imm : i_rs2_data;
    shamt  = opB[SW-1:0];
    aluRes = '0;
    case (i_alu_op)
      4'd0:    aluRes = opA + opB;
      4'd1:    aluRes = opA - opB;
      4'd2:    aluRes = opA << shamt;
      4'd3:    aluRes = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      4'd4:    aluRes = {{(XLEN-1){1'b0}}, (opA < opB)};
      4'd5:    aluRes = opA ^ opB;
      4'd6:    aluRes = opA >> shamt;
      4'd7:    aluRes = $signed(opA) >>> shamt;
      4'd8:    aluRes = opA | opB;
      4'd9:    aluRes = opA & opB;
      4'd10:   aluRes = opB;
      default: aluRes = '0;
    endcase
    brEqual_d = (i_rs1_data == i_rs2_data);
    brLess_d  = i_br_un ? (i_rs1_data < i_rs2_data)
                        : ($signed(i_rs1_data) < $signed(i_rs2_data));
  end

  // MD operands are reduced to magnitudes; which operands count as signed
  // depends on the op (MUL low half is sign-agnostic, so treated unsigned).
  always_comb begin
    signA = (i_md_op == 3'd1) || (i_md_op == 3'd2) ||
            (i_md_op == 3'd4) || (i_md_op == 3'd6);
    signB = (i_md_op == 3'd1) || (i_md_op == 3'd4) || (i_md_op == 3'd6);
    negA  = signA && i_rs1_data[XLEN-1];
    negB  = signB && i_rs2_data[XLEN-1];
    magA  = negA ? -i_rs1_data : i_rs1_data;
    magB  = negB ? -i_rs2_data : i_rs2_data;
  end

`ifdef STAGEEX_MD_FASTMUL_EN
  logic [2*XLEN-1:0] fastA;
  logic [2*XLEN-1:0] fastB;
  logic [2*XLEN-1:0] fastProd;

  // Sign-extending both operands to 2*XLEN makes the truncated product
  // correct for every signedness mix, so one multiplier covers all four ops.
  always_comb begin
    fastA      = {{XLEN{negA}}, i_rs1_data};
    fastB      = {{XLEN{negB}}, i_rs2_data};
    fastProd   = fastA * fastB;
    issueRes_d = aluRes;
    if (i_md_en) begin
      issueRes_d = (i_md_op == 3'd0) ? fastProd[XLEN-1:0]
                                     : fastProd[2*XLEN-1:XLEN];
    end
  end

  assign iterStart = accept && i_md_en && i_md_op[2];
`else
  assign issueRes_d = aluRes;
  assign iterStart  = accept && i_md_en;
`endif

  // One radix-2 step on acc_q. Divide: acc = {remainder, dividend/quotient},
  // restoring subtract. Multiply: acc = {partial high, multiplier}, add then
  // shift right. The sign fix-up and special cases are applied to the step's
  // output so the finished value can be registered on the CALC->DONE edge.
  always_comb begin
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = shifted - {1'b0, mcand_q};
    mulSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
              (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = {mulSum, acc_q[XLEN-1:1]};
    end
    prodFix = negQ_q ? -acc_d : acc_d;
    quo     = negQ_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem     = negR_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:       result_d = prodFix[XLEN-1:0];
      3'd4, 3'd5: result_d = divZero_q ? {XLEN{1'b1}} : quo;
      3'd6, 3'd7: result_d = divZero_q ? dividend_q : rem;
      default:    result_d = prodFix[2*XLEN-1:XLEN];
    endcase
  end

  // Stage FSM. IDLE accepts work; single-cycle results go straight to the
  // output registers, iterative ops latch magnitudes and spend XLEN cycles in
  // CALC. The compare for an iterative op is held aside and only published
  // together with its result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      brLess_q    <= 1'b0;
      brEqual_q   <= 1'b0;
      pendLess_q  <= 1'b0;
      pendEqual_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      dividend_q  <= '0;
      op_q        <= '0;
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
      divZero_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iterStart) begin
            state_q     <= CALC;
            busy_q      <= 1'b1;
            cnt_q       <= SW'(XLEN-1);
            acc_q       <= {{XLEN{1'b0}}, magA};
            mcand_q     <= magB;
            dividend_q  <= i_rs1_data;
            op_q        <= i_md_op;
            negQ_q      <= negA ^ negB;
            negR_q      <= negA;
            divZero_q   <= (i_rs2_data == '0);
            pendLess_q  <= brLess_d;
            pendEqual_q <= brEqual_d;
          end else if (accept) begin
            valid_q   <= 1'b1;
            result_q  <= issueRes_d;
            brLess_q  <= brLess_d;
            brEqual_q <= brEqual_d;
          end
        end
        CALC: begin
          if (i_flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - SW'(1);
            if (cnt_q == '0) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              cnt_q     <= '0;
              valid_q   <= 1'b1;
              result_q  <= result_d;
              brLess_q  <= pendLess_q;
              brEqual_q <= pendEqual_q;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush landing in DONE kills the result pulse that is already showing.
  assign o_valid    = valid_q && !(i_flush && (state_q == DONE));
  assign o_result   = result_q;
  assign o_br_less  = brLess_q;
  assign o_br_equal = brEqual_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_stageex_md.sv
// ---------------------------------------------------------------------------
// tb_stageex_md : self-checking bench for stageex_md (XLEN = 32)
//
// A behavioural model predicts, per instruction, the cycle its result must
// appear, the result itself and the branch compare. A compare process checks
// o_ready, o_busy, o_valid, o_result and the compare outputs every cycle.
// Directed vectors also carry hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_stageex_md;

  localparam int XLEN = 32;
`ifdef STAGEEX_MD_FASTMUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk;
  logic            i_reset;
  logic            i_valid;
  logic            o_ready;
  logic            i_flush;
  logic            i_opa_sel;
  logic            i_opb_sel;
  logic            i_br_un;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [XLEN-1:0] i_imm;
  logic [3:0]      i_alu_op;
  logic            i_md_en;
  logic [2:0]      i_md_op;
  logic            o_valid;
  logic [XLEN-1:0] o_result;
  logic            o_br_less;
  logic            o_br_equal;
  logic            o_busy;

  stageex_md #(.XLEN(XLEN)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_flush    (i_flush),
    .i_opa_sel  (i_opa_sel),
    .i_opb_sel  (i_opb_sel),
    .i_br_un    (i_br_un),
    .i_pc       (i_pc),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_imm      (i_imm),
    .i_alu_op   (i_alu_op),
    .i_md_en    (i_md_en),
    .i_md_op    (i_md_op),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_br_less  (o_br_less),
    .o_br_equal (o_br_equal),
    .o_busy     (o_busy)
  );

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic        less;
    logic        eq;
    logic        hasPin;
    logic [31:0] pin;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rstEdge = 1'b0;
  logic        chkOn = 1'b0;
  int          readyFrom = 0;
  int          busyStart = 0;
  int          busyEnd = 0;
  int          lastAccept = 0;
  logic [31:0] lastResult = '0;
  logic        lastLess = 1'b0;
  logic        lastEq = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number = count of rising edges so far; also remember whether the
  // most recent edge saw reset.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rstEdge <= i_reset;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mdModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin t = sa * sb; return t[31:0]; end
      3'd1: begin t = sa * sb; return t[63:32]; end
      3'd2: begin t = sa * longint'(ub); return t[63:32]; end
      3'd3: begin t = ua * ub; return t[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        t = sa / sb; return t[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        t = ua / ub; return t[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; return t[31:0];
      end
      default: begin
        if (b == 0) return a;
        t = ua % ub; return t[31:0];
      end
    endcase
  endfunction

  // Per-cycle compare of every output against the model's expectations.
  always @(negedge clk) begin
    exp_t e;
    logic expReady, expBusy;
    if (chkOn) begin
      expReady = !i_reset && (cyc >= readyFrom);
      expBusy  = (cyc >= busyStart) && (cyc < busyEnd);
      checkOutput("o_ready", {31'd0, o_ready}, {31'd0, expReady});
      checkOutput("o_busy", {31'd0, o_busy}, {31'd0, expBusy});
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        checkOutput("o_valid_pulse", {31'd0, o_valid}, 32'd1);
        checkOutput("o_result", o_result, e.res);
        checkOutput("o_br_less", {31'd0, o_br_less}, {31'd0, e.less});
        checkOutput("o_br_equal", {31'd0, o_br_equal}, {31'd0, e.eq});
        if (e.hasPin) checkOutput("literal_result", o_result, e.pin);
        lastResult = e.res;
        lastLess   = e.less;
        lastEq     = e.eq;
      end else begin
        checkOutput("o_valid_idle", {31'd0, o_valid}, 32'd0);
        checkOutput("o_result_hold", o_result, lastResult);
        checkOutput("o_br_less_hold", {31'd0, o_br_less}, {31'd0, lastLess});
        checkOutput("o_br_equal_hold", {31'd0, o_br_equal}, {31'd0, lastEq});
      end
      if (rstEdge) begin
        checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("reset_result", o_result, 32'd0);
        checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("reset_br", {30'd0, o_br_less, o_br_equal}, 32'd0);
      end
    end
  end

  // Present one instruction once the model says the stage is free, and
  // record where and what its result must be.
  task automatic applyStimulus(input logic md, input logic [3:0] aop, input logic [2:0] mop,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic aSel, input logic bSel, input logic brUn,
                               input logic flushIn, input logic hasPin, input logic [31:0] pin);
    int   guard = 0;
    int   lat;
    exp_t e;
    logic [31:0] a, b;
    while (cyc < readyFrom && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_wait_timeout actual=busy expected=ready");
    end
    i_md_en = md; i_alu_op = aop; i_md_op = mop;
    i_rs1_data = rs1; i_rs2_data = rs2; i_pc = pc; i_imm = imm;
    i_opa_sel = aSel; i_opb_sel = bSel; i_br_un = brUn;
    i_flush = flushIn; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    if (!flushIn) begin
      lastAccept = cyc;
      a = aSel ? pc : rs1;
      b = bSel ? imm : rs2;
      if (md) begin
        lat   = (FAST && !mop[2]) ? 1 : XLEN + 1;
        e.res = mdModel(mop, rs1, rs2);
      end else begin
        lat   = 1;
        e.res = aluModel(aop, a, b);
      end
      e.cyc    = cyc + lat - 1;
      e.eq     = (rs1 == rs2);
      e.less   = brUn ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
      e.hasPin = hasPin;
      e.pin    = pin;
      expQ.push_back(e);
      if (lat > 1) begin
        readyFrom = cyc + lat;
        busyStart = cyc;
        busyEnd   = cyc + lat - 1;
      end
    end
  endtask

  task automatic aluOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pin);
    applyStimulus(1'b0, op, 3'd0, a, b, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pin);
  endtask

  task automatic mdOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pin);
    applyStimulus(1'b1, 4'd0, op, a, b, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pin);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    i_opa_sel = 1'b0; i_opb_sel = 1'b0; i_br_un = 1'b0;
    i_pc = '0; i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
    i_alu_op = '0; i_md_en = 1'b0; i_md_op = '0;
    @(posedge clk); #1;
    chkOn = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    readyFrom = cyc;

    // ALU directed vectors, issued back to back
    aluOp(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    aluOp(4'd7,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
    aluOp(4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
    aluOp(4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    aluOp(4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    aluOp(4'd2,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
    aluOp(4'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
    aluOp(4'd5,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    aluOp(4'd8,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    aluOp(4'd9,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    aluOp(4'd11, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
    aluOp(4'd15, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
    // pc + imm, PASSB of imm, unsigned and equal compares
    applyStimulus(1'b0, 4'd0, 3'd0, 32'd3, 32'd4, 32'h1000, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1010);
    applyStimulus(1'b0, 4'd10, 3'd0, 32'd3, 32'd4, 32'h1000, 32'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD);
    applyStimulus(1'b0, 4'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000);
    applyStimulus(1'b0, 4'd1, 3'd0, 32'h55, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);

    // flush together with valid in IDLE: discarded, no result
    applyStimulus(1'b0, 4'd0, 3'd0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // multiply / divide directed vectors
    mdOp(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    mdOp(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    mdOp(3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    mdOp(3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    mdOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    mdOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    mdOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mdOp(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1);
    mdOp(3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF);
    mdOp(3'd1, 32'h4000_0000, 32'h0000_0004, 32'h0000_0001);
    mdOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mdOp(3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF);
    mdOp(3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB);
    mdOp(3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
    mdOp(3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);

    // DIV killed by flush in CALC cycle 10, then an ADD goes through
    mdOp(3'd4, 32'h0000_0064, 32'h0000_0003, 32'h0000_0021);
    while (cyc < lastAccept + 9) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    void'(expQ.pop_back());
    readyFrom = cyc + 1;
    busyEnd   = cyc + 1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    aluOp(4'd0, 32'd2, 32'd3, 32'd5);

    // reset pulsed mid-CALC abandons the divide
    mdOp(3'd5, 32'h0000_1000, 32'h0000_0010, 32'h0000_0100);
    repeat (5) begin @(posedge clk); #1; end
    i_reset = 1'b1;
    @(posedge clk); #1;
    expQ.delete();
    readyFrom  = cyc;
    busyEnd    = cyc;
    lastResult = '0;
    lastLess   = 1'b0;
    lastEq     = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    aluOp(4'd0, 32'd10, 32'd20, 32'd30);

    repeat (40) @(posedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stageex_md.md
STAGEEX_MD -- requirements
Module: stageex_md

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 i_clk  in  1  single clock, all state updates on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_valid  in  1  upstream presents an instruction.
REQ-005 o_ready  out  1  stage accepts; transfer occurs on edge where i_valid && o_ready.
REQ-006 i_flush  in  1  kill in-flight operation.
REQ-007 i_opa_sel, i_opb_sel  in  1 each  0: rs1/rs2, 1: pc/imm.
REQ-008 i_br_un  in  1  1: unsigned branch compare.
REQ-009 i_pc, i_rs1_data, i_rs2_data, i_imm  in  XLEN each  operands.
REQ-010 i_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, others yield 0.
REQ-011 i_md_en  in  1  1: multiply/divide op, i_md_op overrides i_alu_op.
REQ-012 i_md_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M/RV64M semantics on XLEN).
REQ-013 o_valid  out  1  one-cycle pulse, o_result/o_br_* valid.
REQ-014 o_result  out  XLEN  registered result.
REQ-015 o_br_less, o_br_equal  out  1 each  registered rs1-vs-rs2 compare per i_br_un.
REQ-016 o_busy  out  1  high while a multi-cycle op is in progress.

Function
REQ-017 States IDLE, CALC, DONE; o_ready SHALL be 1 only in IDLE.
REQ-018 ALU op accepted in IDLE: result, compare registered at accepting edge; o_valid high the next cycle; stays IDLE (back-to-back throughput 1/cycle).
REQ-019 Shift amount SHALL be low log2(XLEN) bits of operand B; SLT/SLTU output zero-extended 0/1.
REQ-020 Iterative MD op accepted: IDLE->CALC, operands latched, iteration counter loaded XLEN-1; one radix-2 step per cycle.
REQ-021 CALC->DONE when counter reaches 0 (exactly XLEN CALC cycles); DONE asserts o_valid, o_busy=0, o_ready=0, then ->IDLE.
REQ-022 Iterative latency: o_valid in cycle XLEN+1 after the accepting edge.
REQ-023 Signed ops SHALL operate on magnitudes with sign fix-up applied in DONE; MULH* return upper XLEN bits of 2*XLEN product.
REQ-024 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU remainder = dividend; SHALL take full iterative latency.
REQ-025 Signed overflow (most-negative / -1): DIV returns dividend, REM returns 0.
REQ-026 o_br_less/o_br_equal for MD ops SHALL reflect latched rs1/rs2 and appear with o_valid.
REQ-027 i_flush in CALC or DONE: ->IDLE next edge, no o_valid; i_flush in IDLE suppresses o_valid of that cycle's acceptance.
REQ-028 i_flush and i_valid same IDLE cycle: instruction discarded, not accepted.
REQ-029 o_result SHALL hold last value when o_valid is 0.

Reset
REQ-030 i_reset SHALL dominate flush and handshake: state IDLE, o_valid 0, o_result 0, o_br_less 0, o_br_equal 0, o_busy 0, counter 0.
REQ-031 o_ready SHALL be 0 while i_reset high and 1 the first cycle after deassertion.
REQ-032 Reset mid-CALC SHALL abandon the operation with no o_valid.

Configuration
REQ-033 Macro STAGEEX_MD_FASTMUL_EN defined: MUL/MULH/MULHSU/MULHU use single-cycle combinational multiplier, follow REQ-018 timing; DIV/REM remain iterative.
REQ-034 Macro undefined: all MD ops iterative per REQ-020..022; no combinational multiplier instantiated.

Verification
REQ-035 XLEN=32, ADD rs1=0x7FFFFFFF rs2=1 opb_sel=0 -> next cycle o_valid=1, o_result=0x80000000; SRA 0x80000000 by 0x21 -> 0xC0000000.
REQ-036 DIV rs1=-7 rs2=2 -> o_valid exactly 33 cycles after accept, result 0xFFFFFFFD; REM -> 0xFFFFFFFF; o_ready 0 throughout.
REQ-037 DIVU rs1=5 rs2=0 -> 0xFFFFFFFF; REMU -> 5; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-038 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; latency 1 with STAGEEX_MD_FASTMUL_EN, 33 without.
REQ-039 DIV accepted, i_flush at CALC cycle 10 -> no o_valid, o_ready=1 next cycle; ADD then accepted normally.
REQ-040 i_reset pulsed mid-CALC -> all outputs 0 during reset, o_ready=1 one cycle after release, no stale o_valid.
